// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem request/grant/response,
// and a small in-order FIFO presenting words to decode with valid/ready.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc_plus4
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

  state_t        state, state_n;
  logic [31:0]   fetch_pc, req_pc;
  logic [31:0]   fifo_data [DEPTH];
  logic [31:0]   fifo_pc   [DEPTH];
  logic [AW-1:0] rptr, wptr;
  logic [AW:0]   count;
  logic          push, pop, grant;
  logic [AW+1:0] occ_next;
  logic [31:0]   redirect_target;

  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

  assign push        = (state == S_WAIT) & imem_rvalid & ~redirect;
  // Outputs that must read idle during reset are gated by reset directly.
  assign instr_valid = reset & (count != '0) & ~redirect;
  assign pop         = instr_valid & instr_ready;
  assign occ_next    = {1'b0, count} + (AW+2)'(push) - (AW+2)'(pop);

  assign imem_req  = reset & ~redirect
                   & ((state == S_IDLE) | ((state == S_WAIT) & imem_rvalid))
                   & (occ_next < DEPTH_W);
  assign imem_addr = fetch_pc;
  assign grant     = imem_req & imem_gnt;

  always_comb begin
    state_n = state;
    if (redirect) begin
      case (state)
        S_WAIT:  state_n = imem_rvalid ? S_IDLE : S_DROP;
        S_DROP:  state_n = imem_rvalid ? S_IDLE : S_DROP;
        default: state_n = S_IDLE;
      endcase
    end else begin
      case (state)
        S_IDLE:  if (grant) state_n = S_WAIT;
        S_WAIT:  if (imem_rvalid) state_n = grant ? S_WAIT : S_IDLE;
        S_DROP:  if (imem_rvalid) state_n = S_IDLE;
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      count    <= '0;
      rptr     <= '0;
      wptr     <= '0;
    end else begin
      state <= state_n;
      if (redirect) begin
        fetch_pc <= redirect_target;
        count    <= '0;
        rptr     <= '0;
        wptr     <= '0;
      end else begin
        if (grant) begin
          req_pc   <= fetch_pc;
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (push) wptr <= wptr + AW'(1);
        if (pop)  rptr <= rptr + AW'(1);
        count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wptr] <= imem_rdata;
      fifo_pc[wptr]   <= req_pc;
    end
  end

  assign instr          = instr_valid ? fifo_data[rptr] : 32'h0000_0013;
  assign instr_pc       = instr_valid ? fifo_pc[rptr] : 32'h0000_0000;
  assign instr_pc_plus4 = instr_pc + 32'd4;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed phases plus random traffic, checked against a
// stream-level model (each redirect restarts a contiguous word stream).
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, redirect, imem_req, imem_gnt, imem_rvalid;
  logic        instr_valid, instr_ready;
  logic [31:0] redirect_pc, imem_addr, imem_rdata, instr, instr_pc, instr_pc_plus4;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0100), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .instr_pc(instr_pc), .instr_pc_plus4(instr_pc_plus4)
  );

  int          n_cmp = 0, n_err = 0;
  logic [31:0] exp_pc, exp_fetch;
  bit          pend, prev_req_ng, last_req;
  logic [31:0] pend_addr;
  int          pend_cnt, ngrant, n0;
  int          gnt_mode, ready_mode, lat_min, lat_max;
  logic [31:0] pop_log[$];
  logic [31:0] p4_log[$];
  bit          found;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_rvalid = 1'b0; imem_rdata = '0; instr_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      imem_gnt = 1'($urandom_range(0, 1));
      #1;
      chk("rst_req",   {31'b0, imem_req}, 32'd0);
      chk("rst_valid", {31'b0, instr_valid}, 32'd0);
      chk("rst_instr", instr, 32'h0000_0013);
      chk("rst_pc",    instr_pc, 32'd0);
      chk("rst_p4",    instr_pc_plus4, 32'd4);
      @(posedge clk); @(negedge clk);
    end
    reset = 1'b1;
    pend = 1'b0; prev_req_ng = 1'b0;
    exp_pc = 32'h0000_0100; exp_fetch = 32'h0000_0100;
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic cycle(input bit do_redir = 1'b0, input logic [31:0] tgt = '0,
                       input bit stale_rv = 1'b0, input bit exp_noreq = 1'b0,
                       input bit exp_req = 1'b0, input bit exp_valid = 1'b0);
    bit deliver, g, p;
    deliver     = pend && (pend_cnt == 0);
    redirect    = do_redir;
    redirect_pc = do_redir ? tgt : $urandom;
    imem_rvalid = deliver | stale_rv;
    imem_rdata  = deliver ? memfn(pend_addr) : $urandom;
    case (gnt_mode)
      0:       imem_gnt = 1'($urandom_range(0, 1));
      1:       imem_gnt = 1'b1;
      default: imem_gnt = 1'b0;
    endcase
    case (ready_mode)
      0:       instr_ready = 1'($urandom_range(0, 1));
      1:       instr_ready = 1'b1;
      default: instr_ready = 1'b0;
    endcase
    #1;
    if (do_redir) begin
      chk("redir_valid", {31'b0, instr_valid}, 32'd0);
      chk("redir_req",   {31'b0, imem_req}, 32'd0);
    end
    if (exp_noreq) chk("drop_noreq", {31'b0, imem_req}, 32'd0);
    if (exp_req)   chk("req_on",     {31'b0, imem_req}, 32'd1);
    if (exp_valid) chk("throughput", {31'b0, instr_valid}, 32'd1);
    if (prev_req_ng && !do_redir) chk("req_hold", {31'b0, imem_req}, 32'd1);
    if (imem_req) chk("imem_addr", imem_addr, exp_fetch);
    if (instr_valid) begin
      chk("instr_pc", instr_pc, exp_pc);
      chk("instr",    instr, memfn(exp_pc));
      chk("pc_plus4", instr_pc_plus4, exp_pc + 32'd4);
    end else begin
      chk("idle_instr", instr, 32'h0000_0013);
      chk("idle_pc",    instr_pc, 32'd0);
      chk("idle_p4",    instr_pc_plus4, 32'd4);
    end
    g = imem_req & imem_gnt;
    p = instr_valid & instr_ready;
    if (g) chk("one_outstanding", {31'b0, pend && !deliver}, 32'd0);
    last_req    = imem_req;
    prev_req_ng = imem_req & ~imem_gnt;
    if (p) begin
      pop_log.push_back(instr_pc);
      p4_log.push_back(instr_pc_plus4);
    end
    if (do_redir) begin
      exp_pc    = tgt & 32'hFFFF_FFFC;
      exp_fetch = tgt & 32'hFFFF_FFFC;
    end else begin
      if (p) exp_pc = exp_pc + 32'd4;
      if (g) exp_fetch = exp_fetch + 32'd4;
    end
    if (deliver) pend = 1'b0;
    else if (pend) pend_cnt--;
    if (g) begin
      pend      = 1'b1;
      pend_addr = imem_addr;
      pend_cnt  = int'($urandom_range(lat_min, lat_max)) - 1;
      ngrant++;
    end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic run_until_pops(input int want, input int bound, input string tag);
    found = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (pop_log.size() >= want) begin found = 1'b1; break; end
      cycle();
    end
    chk(tag, {31'b0, found}, 32'd1);
  endtask

  initial begin
    ngrant = 0; gnt_mode = 1; ready_mode = 1; lat_min = 1; lat_max = 1;
    do_reset(3);

    // Sequential fetch at full throughput from RESET_PC.
    cycle(.exp_req(1'b1));
    cycle();
    for (int i = 0; i < 10; i++) cycle(.exp_valid(1'b1));

    // Mid-run reset; a stale response after reset must be ignored; then backpressure.
    do_reset(2);
    ready_mode = 2; gnt_mode = 2;
    cycle(.stale_rv(1'b1), .exp_req(1'b1));
    gnt_mode = 1; n0 = ngrant;
    for (int i = 0; i < 6; i++) cycle();
    cycle(.exp_noreq(1'b1), .exp_valid(1'b1));
    chk("bp_grants", 32'(ngrant - n0), 32'd2);
    ready_mode = 1; pop_log.delete(); p4_log.delete();
    run_until_pops(2, 10, "bp_drain_to");
    if (pop_log.size() >= 2) begin
      chk("bp_first",  pop_log[0], 32'h0000_0100);
      chk("bp_second", pop_log[1], 32'h0000_0104);
    end

    // Redirect while waiting; stale response arrives two cycles later.
    lat_min = 3; lat_max = 3; found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (pend && pend_cnt == 2) begin found = 1'b1; break; end
      cycle();
    end
    chk("wait_found", {31'b0, found}, 32'd1);
    cycle(.do_redir(1'b1), .tgt(32'h0000_0200));
    cycle(.exp_noreq(1'b1));
    cycle(.exp_noreq(1'b1));
    cycle(.exp_req(1'b1));
    pop_log.delete(); p4_log.delete();
    run_until_pops(1, 30, "rw_pop_to");
    if (pop_log.size() >= 1) chk("rw_first", pop_log[0], 32'h0000_0200);

    // Redirect in the same cycle as the response.
    lat_min = 2; lat_max = 2; found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (pend && pend_cnt == 0) begin found = 1'b1; break; end
      cycle();
    end
    chk("resp_found", {31'b0, found}, 32'd1);
    cycle(.do_redir(1'b1), .tgt(32'h0000_0300));
    cycle(.exp_req(1'b1));

    // Grant stall: address holds and fetch_pc advances only on the grant.
    lat_min = 1; lat_max = 1; gnt_mode = 2; found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (last_req) begin found = 1'b1; break; end
    end
    chk("stall_req_to", {31'b0, found}, 32'd1);
    n0 = ngrant;
    for (int i = 0; i < 3; i++) cycle();
    chk("stall_nogrant", 32'(ngrant - n0), 32'd0);
    gnt_mode = 1;
    cycle(.exp_req(1'b1));
    chk("stall_grant", 32'(ngrant - n0), 32'd1);

    // Misaligned redirect near the top of the address space wraps to zero.
    cycle(.do_redir(1'b1), .tgt(32'hFFFF_FFFE));
    pop_log.delete(); p4_log.delete();
    run_until_pops(2, 20, "wrap_to");
    if (pop_log.size() >= 2) begin
      chk("wrap_pc0", pop_log[0], 32'hFFFF_FFFC);
      chk("wrap_p4",  p4_log[0],  32'h0000_0000);
      chk("wrap_pc1", pop_log[1], 32'h0000_0000);
    end

    // Random traffic: grants, latencies, backpressure and redirects.
    gnt_mode = 0; ready_mode = 0; lat_min = 1; lat_max = 3;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 15) == 0) cycle(.do_redir(1'b1), .tgt($urandom));
      else cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
